// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for regfile_write_arbiter: WB request, LU result/issue, scoreboard and rf write port.
interface regfile_write_arbiter_if #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int BUF_DEPTH = 2
);
   localparam int NREG  = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              lu_valid;
   logic [ADDR_W-1:0] lu_addr;
   logic [DATA_W-1:0] lu_data;
   logic              lu_ready;
   logic              lu_issue;
   logic [ADDR_W-1:0] lu_issue_addr;
   logic [NREG-1:0]   busy_vec;
   logic              issue_conflict;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [CNT_W-1:0]  buf_count;

   modport master (
      output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data, lu_issue, lu_issue_addr,
      input  lu_ready, busy_vec, issue_conflict, rf_we, rf_waddr, rf_wdata, buf_count
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data, lu_issue, lu_issue_addr,
      output lu_ready, busy_vec, issue_conflict, rf_we, rf_waddr, rf_wdata, buf_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB always wins, LU results wait in a small FIFO, busy scoreboard.
// Optional macro REGFILE_ARB_BYPASS_EN lets an LU result skip the empty FIFO when WB is idle.
module regfile_write_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int BUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_write_arbiter_if.slave bus
);
   localparam int NREG  = 2 ** ADDR_W;
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   wr_req_t           mem [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [NREG-1:0]   busy, busy_nxt;
   logic              conflict;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;

   logic    accept, byp, push, pop, grant, grant_lu;
   wr_req_t grant_req, lu_req;

   assign bus.lu_ready       = (count < CNT_W'(BUF_DEPTH));
   assign bus.buf_count      = count;
   assign bus.busy_vec       = busy;
   assign bus.issue_conflict = conflict;
   assign bus.rf_we          = we_q;
   assign bus.rf_waddr       = waddr_q;
   assign bus.rf_wdata       = wdata_q;

   assign lu_req = '{addr: bus.lu_addr, data: bus.lu_data};
   assign accept = bus.lu_valid && bus.lu_ready;

`ifdef REGFILE_ARB_BYPASS_EN
   // Only when nothing is queued, so FIFO order is never violated.
   assign byp = accept && (count == '0) && !bus.wb_valid;
`else
   assign byp = 1'b0;
`endif

   assign push     = accept && !byp;
   assign pop      = !bus.wb_valid && (count != '0);
   assign grant    = bus.wb_valid || pop || byp;
   assign grant_lu = !bus.wb_valid && (pop || byp);

   always_comb begin
      grant_req = '{addr: bus.wb_addr, data: bus.wb_data};
      if (!bus.wb_valid) grant_req = pop ? mem[rd_ptr] : lu_req;
   end

   // Set wins over clear: a re-issue to the register being retired keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (grant_lu) busy_nxt[grant_req.addr] = 1'b0;
      if (bus.lu_issue && (bus.lu_issue_addr != '0)) busy_nxt[bus.lu_issue_addr] = 1'b1;
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= lu_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         busy     <= '0;
         conflict <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         busy     <= busy_nxt;
         conflict <= bus.lu_issue && busy[bus.lu_issue_addr];
         // Writes to r0 still consume their grant and FIFO slot, but never reach the rf.
         we_q     <= grant && (grant_req.addr != '0);
         if (grant) begin
            waddr_q <= grant_req.addr;
            wdata_q <= grant_req.data;
         end
      end
   end
endmodule
